// File: rtl/word_descrambler16.sv
// word_descrambler16: receive-side descrambler for 16-bit words.
// Each accepted word is XORed with the current Galois LFSR state, then the
// LFSR jumps 16 steps ahead. Data passes only after the LFSR has been seeded
// with the transmitter's seed (SYNC). Until then accepted words are
// discarded and counted.
module word_descrambler16 #(
  parameter int unsigned           WIDTH = 16,            // only 16 is supported
  parameter logic [WIDTH-1:0]      POLY  = 16'hB400,      // x^16+x^14+x^13+x^11+1
  parameter logic [WIDTH-1:0]      SEED  = 16'hACE1       // reset state and zero-seed substitute
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             synced,
  output logic [WIDTH-1:0] drop_cnt
);

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] drop_cnt_q;

  logic [WIDTH-1:0] lfsr_d;   // LFSR advanced by one full word (16 steps)
  logic [WIDTH-1:0] seed_d;   // seed actually loaded; zero would lock the LFSR
  logic             accept;

  // Sixteen Galois steps unrolled into one combinational jump.
  function automatic logic [WIDTH-1:0] adv16(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < 16; i++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign lfsr_d = adv16(lfsr_q);
  assign seed_d = (seed_in == '0) ? SEED : seed_in;

  // In UNSYNC the output stage is always empty, so words can always be
  // swallowed; in SYNC the single output register must be free or draining.
  assign in_ready = !seed_load && ((state_q == UNSYNC) || !out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Sync FSM plus output register, drop counter and keystream state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNSYNC;
      lfsr_q      <= SEED;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drop_cnt_q  <= '0;
    end else if (seed_load) begin
      // Resync: pending output word is flushed and not counted as a drop.
      state_q     <= SYNC;
      lfsr_q      <= seed_d;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        UNSYNC: begin
          if (accept) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
          end
        end
        SYNC: begin
          if (accept) begin
            out_data_q  <= in_data ^ lfsr_q;
            out_valid_q <= 1'b1;
            lfsr_q      <= lfsr_d;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= UNSYNC;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign synced    = (state_q == SYNC);
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_word_descrambler16.sv
// Self-checking bench for word_descrambler16. A transaction-level model
// (sync flag, keystream word, drop count, queue of expected plaintext)
// predicts every observable output.
module tb_word_descrambler16;

  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        synced;
  logic [15:0] drop_cnt;

  int vectors    = 0;
  int miscompares = 0;

  // reference model state
  bit          m_sync;
  logic [15:0] m_key;
  logic [15:0] m_drop;
  logic [15:0] exp_q[$];

  word_descrambler16 dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .synced(synced), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Keystream advance by one word: 16 Galois shifts done arithmetically.
  function automatic logic [15:0] adv16(input logic [15:0] s);
    int unsigned v;
    v = s;
    for (int i = 0; i < 16; i++) v = (v % 2 == 1) ? ((v / 2) ^ POLY) : (v / 2);
    return v[15:0];
  endfunction

  function automatic bit m_ready();
    return !seed_load && (!m_sync || exp_q.size() == 0 || out_ready);
  endfunction

  task automatic model_reset();
    m_sync = 0; m_key = SEED; m_drop = 16'h0000; exp_q.delete();
  endtask

  task automatic drive(input bit sl, input logic [15:0] si, input bit iv,
                       input logic [15:0] id, input bit ordy);
    seed_load = sl; seed_in = si; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
  endtask

  // One clock edge; the model consumes the same inputs the DUT sees.
  task automatic tick();
    bit rdy;
    rdy = m_ready();
    @(posedge clk);
    if (seed_load) begin
      exp_q.delete();
      m_key  = (seed_in == 16'h0000) ? SEED : seed_in;
      m_sync = 1;
    end else begin
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && rdy) begin
        if (!m_sync) m_drop = m_drop + 16'd1;
        else begin
          exp_q.push_back(in_data ^ m_key);
          m_key = adv16(m_key);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 16'h0, 0, 16'h0, 0);
    #2;
    model_reset();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
    vectors++; if (synced !== 1'b0) begin miscompares++; $display("FAIL reset_synced: got %b expected 0", synced); end
    vectors++; if (drop_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_drop_cnt: got %h expected 0000", drop_cnt); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_seed_basic();
    logic [15:0] k;
    drive(1, 16'hACE1, 0, 16'h0, 1); tick();
    vectors++; if (synced !== 1'b1) begin miscompares++; $display("FAIL seed_synced: got %b expected 1", synced); end
    drive(0, 16'h0, 1, 16'hACE1, 1);
    tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h0000) begin miscompares++; $display("FAIL seed_first_word: got v=%b d=%h expected v=1 d=0000", out_valid, out_data); end
    drive(1, 16'hACE1, 0, 16'h0, 1); tick();
    k = 16'hACE1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 16'h0, 1, 16'h0000, 1); tick();
      vectors++; if (out_valid !== 1'b1 || out_data !== k) begin miscompares++; $display("FAIL keystream_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, k); end
      $display("keystream word %0d = %h", i, out_data);
      k = adv16(k);
    end
    drive(0, 16'h0, 0, 16'h0, 1); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL seed_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_unsync();
    #2; rst_n = 1'b0; #1; model_reset();
    @(posedge clk); #3; rst_n = 1'b1; @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 16'h0, 1, 16'($urandom), 1);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL unsync_in_ready_%0d: got %b expected 1", i, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL unsync_out_valid_%0d: got %b expected 0", i, out_valid); end
    end
    vectors++; if (drop_cnt !== 16'd5 || drop_cnt !== m_drop) begin miscompares++; $display("FAIL unsync_drop_cnt: got %0d expected 5", drop_cnt); end
    drive(1, 16'h1234, 1, 16'h0, 1);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL seedload_in_ready: got %b expected 0", in_ready); end
    tick();
    vectors++; if (drop_cnt !== 16'd5 || synced !== 1'b1) begin miscompares++; $display("FAIL seedload_drop_hold: got cnt=%0d sync=%b expected cnt=5 sync=1", drop_cnt, synced); end
    drive(0, 16'h0, 0, 16'h0, 1); tick();
  endtask

  task automatic test_stall();
    logic [15:0] held;
    drive(0, 16'h0, 1, 16'($urandom), 0); tick();
    held = exp_q.size() > 0 ? exp_q[0] : 16'hxxxx;
    vectors++; if (out_valid !== 1'b1 || out_data !== held) begin miscompares++; $display("FAIL stall_load: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, held); end
    for (int i = 0; i < 4; i++) begin
      drive(0, 16'h0, 1, 16'($urandom), 0);
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready_%0d: got %b expected 0", i, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_data !== held) begin miscompares++; $display("FAIL stall_hold_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, held); end
    end
    for (int i = 0; i < 16; i++) begin
      drive(0, 16'h0, 1, 16'($urandom), 1);
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stream_in_ready_%0d: got %b expected 1", i, in_ready); end
      tick();
      vectors++; if (out_valid !== 1'b1 || exp_q.size() != 1 || out_data !== exp_q[0]) begin miscompares++; $display("FAIL stream_word_%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp_q.size() > 0 ? exp_q[0] : 16'h0); end
    end
    drive(0, 16'h0, 0, 16'h0, 1); tick();
    $display("test_stall done");
  endtask

  task automatic test_seed_flush();
    logic [15:0] w2;
    w2 = 16'($urandom);
    drive(0, 16'h0, 1, 16'($urandom), 0); tick();
    drive(1, 16'h5A5A, 1, w2, 0);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    drive(0, 16'h0, 1, w2, 1); tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== (w2 ^ 16'h5A5A)) begin miscompares++; $display("FAIL flush_resend: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, w2 ^ 16'h5A5A); end
    drive(0, 16'h0, 0, 16'h0, 1); tick();
  endtask

  task automatic test_zero_seed();
    drive(1, 16'h0000, 0, 16'h0, 1); tick();
    drive(0, 16'h0, 1, 16'h0000, 1); tick();
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'hACE1) begin miscompares++; $display("FAIL zero_seed: got v=%b d=%h expected v=1 d=ace1", out_valid, out_data); end
    drive(0, 16'h0, 1, 16'h0000, 1); tick();
    vectors++; if (out_data !== adv16(16'hACE1)) begin miscompares++; $display("FAIL zero_seed_next: got %h expected %h", out_data, adv16(16'hACE1)); end
    drive(0, 16'h0, 0, 16'h0, 1); tick();
  endtask

  task automatic test_random();
    bit sl;
    #2; rst_n = 1'b0; #1; model_reset();
    @(posedge clk); #3; rst_n = 1'b1; @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      sl = ($urandom_range(0, 24) == 0);
      drive(sl, ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
            $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 2) != 0);
      vectors++; if (in_ready !== m_ready()) begin miscompares++; $display("FAIL rnd_in_ready_%0d: got %b expected %b", i, in_ready, m_ready()); end
      tick();
      vectors++; if (out_valid !== (exp_q.size() != 0)) begin miscompares++; $display("FAIL rnd_out_valid_%0d: got %b expected %b", i, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        vectors++; if (out_data !== exp_q[0]) begin miscompares++; $display("FAIL rnd_out_data_%0d: got %h expected %h", i, out_data, exp_q[0]); end
      end
      vectors++; if (synced !== m_sync || drop_cnt !== m_drop) begin miscompares++; $display("FAIL rnd_status_%0d: got sync=%b cnt=%0d expected sync=%b cnt=%0d", i, synced, drop_cnt, m_sync, m_drop); end
    end
    $display("test_random done");
  endtask

  task automatic test_reset_mid();
    drive(1, 16'hBEEF, 0, 16'h0, 0); tick();
    drive(0, 16'h0, 1, 16'($urandom), 0); tick();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_setup: got %b expected 1", out_valid); end
    #2; rst_n = 1'b0; #1;
    model_reset();
    vectors++; if (out_valid !== 1'b0 || synced !== 1'b0) begin miscompares++; $display("FAIL midrst_async: got v=%b sync=%b expected v=0 sync=0", out_valid, synced); end
    vectors++; if (out_data !== 16'h0000 || drop_cnt !== 16'h0000) begin miscompares++; $display("FAIL midrst_regs: got d=%h cnt=%h expected 0000 0000", out_data, drop_cnt); end
    @(posedge clk); #3; rst_n = 1'b1; @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_seed_basic();
    test_unsync();
    test_stall();
    test_seed_flush();
    test_zero_seed();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
